// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg
// Shared definitions for the fetch stage: FSM state encoding, default
// geometry of the PC and the branch-target LUT, and an index-width helper.
// Optional feature macro used by this slice: FETCH_TAKEN_COUNT_EN.
package fetch_unit_pkg;

  localparam int DEFAULT_PC_W      = 10;
  localparam int DEFAULT_LUT_DEPTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  // Width of a LUT index; never below one bit so a depth-1 table still
  // has a legal port.
  function automatic int idx_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if
// Bundles the fetch stage's control, LUT-write and status signals.
//   master : the sequencer / decode side (drives START, STALL, branch
//            controls, FLAG and LUT writes; observes PC and status)
//   slave  : the fetch unit itself
// Handshake: START is a level sampled on every rising edge; while high the
// unit (re)starts at START_ADDR and FETCH_VALID is high from the next edge.
// DONE rises on the edge that takes a HALT_REQ and stays high until the edge
// that samples START again. There is no ready/back-pressure path; STALL is
// the only way to hold the PC.
// 'state' is a debug view of the FSM register.
// Optional feature macro: FETCH_TAKEN_COUNT_EN adds TAKEN_CNT.
interface fetch_unit_if
  import fetch_unit_pkg::*;
#(
  parameter int PC_W      = DEFAULT_PC_W,
  parameter int LUT_DEPTH = DEFAULT_LUT_DEPTH
);
  localparam int IDX_W = idx_w(LUT_DEPTH);

  logic             START;
  logic             STALL;
  logic             BRANCH_EN;
  logic             JUMP_EN;
  logic             HALT_REQ;
  logic [IDX_W-1:0] LUT_IDX;
  logic             FLAG;
  logic             LUT_WE;
  logic [IDX_W-1:0] LUT_WADDR;
  logic [PC_W-1:0]  LUT_WDATA;
  logic [PC_W-1:0]  PROG_CTR;
  logic             FETCH_VALID;
  logic             DONE;
  fetch_state_e     state;
`ifdef FETCH_TAKEN_COUNT_EN
  logic [15:0]      TAKEN_CNT;

  modport master (
    output START, STALL, BRANCH_EN, JUMP_EN, HALT_REQ, LUT_IDX, FLAG,
           LUT_WE, LUT_WADDR, LUT_WDATA,
    input  PROG_CTR, FETCH_VALID, DONE, state, TAKEN_CNT
  );
  modport slave (
    input  START, STALL, BRANCH_EN, JUMP_EN, HALT_REQ, LUT_IDX, FLAG,
           LUT_WE, LUT_WADDR, LUT_WDATA,
    output PROG_CTR, FETCH_VALID, DONE, state, TAKEN_CNT
  );
`else
  modport master (
    output START, STALL, BRANCH_EN, JUMP_EN, HALT_REQ, LUT_IDX, FLAG,
           LUT_WE, LUT_WADDR, LUT_WDATA,
    input  PROG_CTR, FETCH_VALID, DONE, state
  );
  modport slave (
    input  START, STALL, BRANCH_EN, JUMP_EN, HALT_REQ, LUT_IDX, FLAG,
           LUT_WE, LUT_WADDR, LUT_WDATA,
    output PROG_CTR, FETCH_VALID, DONE, state
  );
`endif

endinterface

// File: rtl/fetch_unit_branch_lut.sv
// branch_lut
// Branch-target table: one synchronous write port, one combinational read
// port, asynchronous active-low clear of every entry.
//   clk_i, rst_ni        : clock, async active-low clear
//   we_i/waddr_i/wdata_i : write port (takes effect on the rising edge)
//   raddr_i/rdata_o      : combinational read; out-of-range index reads 0
// A read of the entry being written in the same cycle sees the old value.
module branch_lut
  import fetch_unit_pkg::*;
#(
  parameter int LUT_DEPTH = DEFAULT_LUT_DEPTH,
  parameter int PC_W      = DEFAULT_PC_W,
  localparam int IDX_W    = idx_w(LUT_DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [IDX_W-1:0] waddr_i,
  input  logic [PC_W-1:0]  wdata_i,
  input  logic [IDX_W-1:0] raddr_i,
  output logic [PC_W-1:0]  rdata_o
);

  logic [PC_W-1:0] mem_q [LUT_DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < LUT_DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i && (32'(waddr_i) < 32'(LUT_DEPTH))) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = (32'(raddr_i) < 32'(LUT_DEPTH)) ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// PC / instruction-fetch stage. Holds the PC and chooses the next one from
// restart, hold (stall/halt), LUT target (jump or taken branch) or PC+1.
// Sequences IDLE -> RUN -> HALT with a START/DONE handshake.
//   CLK, RESET_N : clock, asynchronous active-low reset
//   bus (slave)  : controls, FLAG, LUT write port, PROG_CTR, FETCH_VALID,
//                  DONE, debug state (and TAKEN_CNT when enabled)
// Optional feature macro: FETCH_TAKEN_COUNT_EN (16-bit saturating count of
// PC redirects by jumps / taken branches).
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int PC_W       = DEFAULT_PC_W,
  parameter int LUT_DEPTH  = DEFAULT_LUT_DEPTH,
  parameter int START_ADDR = 0
) (
  input  logic        CLK,
  input  logic        RESET_N,
  fetch_unit_if.slave bus
);

  localparam logic [PC_W-1:0] START_PC = PC_W'(START_ADDR);

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic            valid_q, done_q;
  logic [PC_W-1:0] lut_rdata;
  logic [PC_W-1:0] target;
  logic            redirect;
  logic            redirect_taken;

  branch_lut #(
    .LUT_DEPTH (LUT_DEPTH),
    .PC_W      (PC_W)
  ) u_branch_lut (
    .clk_i   (CLK),
    .rst_ni  (RESET_N),
    .we_i    (bus.LUT_WE),
    .waddr_i (bus.LUT_WADDR),
    .wdata_i (bus.LUT_WDATA),
    .raddr_i (bus.LUT_IDX),
    .rdata_o (lut_rdata)
  );

  // Indices past the table (non-power-of-two depth) fall back to START_ADDR.
  assign target   = (32'(bus.LUT_IDX) < 32'(LUT_DEPTH)) ? lut_rdata : START_PC;
  // Jump wins over branch; FLAG only matters for a branch.
  assign redirect = bus.JUMP_EN | (bus.BRANCH_EN & bus.FLAG);

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    redirect_taken = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.START) begin
          state_d = RUN;
          pc_d    = START_PC;
        end
      end
      RUN: begin
        if (bus.START) begin
          pc_d = START_PC;
        end else if (bus.STALL) begin
          pc_d = pc_q;
        end else if (bus.HALT_REQ) begin
          // PC stays on the halt instruction.
          state_d = HALT;
        end else if (redirect) begin
          pc_d           = target;
          redirect_taken = 1'b1;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      HALT: begin
        if (bus.START) begin
          state_d = RUN;
          pc_d    = START_PC;
        end
      end
      default: begin
        state_d = IDLE;
        pc_d    = START_PC;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      pc_q    <= START_PC;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= (state_d == RUN);
      done_q  <= (state_d == HALT);
    end
  end

  assign bus.PROG_CTR    = pc_q;
  assign bus.FETCH_VALID = valid_q;
  assign bus.DONE        = done_q;
  assign bus.state       = state_q;

`ifdef FETCH_TAKEN_COUNT_EN
  logic [15:0] taken_cnt_q, taken_cnt_d;

  always_comb begin
    taken_cnt_d = taken_cnt_q;
    if (bus.START) begin
      taken_cnt_d = '0;
    end else if (redirect_taken && (taken_cnt_q != 16'hFFFF)) begin
      taken_cnt_d = taken_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) taken_cnt_q <= '0;
    else          taken_cnt_q <= taken_cnt_d;
  end

  assign bus.TAKEN_CNT = taken_cnt_q;
`else
  // Kept so the redirect decode reads the same with or without the counter.
  logic unused_redirect_taken;
  assign unused_redirect_taken = redirect_taken;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit
// Directed walk through the fetch stage's rules followed by randomized
// traffic, all checked against a cycle-level reference model.
// Optional feature macro: FETCH_TAKEN_COUNT_EN (enables TAKEN_CNT checks).
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int PC_W   = DEFAULT_PC_W;
  localparam int DEPTH  = DEFAULT_LUT_DEPTH;
  localparam int IDX_W  = idx_w(DEPTH);
  localparam int PC_MOD = 1 << PC_W;
  localparam int START  = 0;

  // ---------------- clock / reset ----------------
  logic CLK     = 1'b0;
  logic RESET_N = 1'b0;
  always #5 CLK = ~CLK;

  fetch_unit_if #(.PC_W(PC_W), .LUT_DEPTH(DEPTH)) bus ();

  fetch_unit #(.PC_W(PC_W), .LUT_DEPTH(DEPTH), .START_ADDR(START)) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [PC_W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_pc;
  bit m_running;
  bit m_halted;
  int m_lut[DEPTH];
  int m_cnt;

  task automatic model_reset();
    m_pc      = START;
    m_running = 0;
    m_halted  = 0;
    m_cnt     = 0;
    for (int i = 0; i < DEPTH; i++) m_lut[i] = 0;
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit start, input bit stall, input bit br, input bit jmp,
                      input bit halt, input bit flag, input int idx,
                      input bit we = 0, input int wa = 0, input int wd = 0);
    int  nxt_pc;
    bit  nxt_run, nxt_halt;
    int  tgt;
    bus.START     = start;
    bus.STALL     = stall;
    bus.BRANCH_EN = br;
    bus.JUMP_EN   = jmp;
    bus.HALT_REQ  = halt;
    bus.FLAG      = flag;
    bus.LUT_IDX   = IDX_W'(idx);
    bus.LUT_WE    = we;
    bus.LUT_WADDR = IDX_W'(wa);
    bus.LUT_WDATA = PC_W'(wd);

    nxt_pc   = m_pc;
    nxt_run  = m_running;
    nxt_halt = m_halted;
    tgt      = (idx < DEPTH) ? m_lut[idx] : START;
    if (start) begin
      // START from any state: run from the start address.
      nxt_run  = 1;
      nxt_halt = 0;
      nxt_pc   = START;
      m_cnt    = 0;
    end else if (m_running && !stall) begin
      if (halt) begin
        nxt_run  = 0;
        nxt_halt = 1;
      end else if (jmp || (br && flag)) begin
        nxt_pc = tgt;
        if (m_cnt < 65535) m_cnt++;
      end else begin
        nxt_pc = (m_pc + 1) % PC_MOD;
      end
    end
    if (we) m_lut[wa] = wd % PC_MOD;
    exp_q.push_back(PC_W'(nxt_pc));

    @(posedge CLK);
    #1;
    m_pc      = nxt_pc;
    m_running = nxt_run;
    m_halted  = nxt_halt;
    check("pc", 32'(bus.PROG_CTR), 32'(exp_q.pop_front()));
    check("fetch_valid", 32'(bus.FETCH_VALID), 32'(m_running));
    check("done", 32'(bus.DONE), 32'(m_halted));
`ifdef FETCH_TAKEN_COUNT_EN
    check("taken_cnt", 32'(bus.TAKEN_CNT), 32'(m_cnt));
`endif
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.START = 0; bus.STALL = 0; bus.BRANCH_EN = 0; bus.JUMP_EN = 0;
    bus.HALT_REQ = 0; bus.FLAG = 0; bus.LUT_IDX = '0; bus.LUT_WE = 0;
    bus.LUT_WADDR = '0; bus.LUT_WDATA = '0;
    model_reset();
    #12;
    check("rst_pc", 32'(bus.PROG_CTR), 32'h0);
    check("rst_valid", 32'(bus.FETCH_VALID), 32'h0);
    check("rst_done", 32'(bus.DONE), 32'h0);
    check("rst_state", 32'(bus.state), 32'(IDLE));
    RESET_N = 1'b1;

    // Start, then sequential fetch while loading the LUT.
    step(1, 0, 0, 0, 0, 0, 0);
    check("start_pc", 32'(bus.PROG_CTR), 32'h0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 3, 'h080);
    step(0, 0, 0, 0, 0, 0, 0, 1, 1, 'h010);
    step(0, 0, 0, 0, 0, 0, 0, 1, 2, 'h3FF);
    step(0, 0, 0, 0, 0, 0, 0, 1, 4, 'h020);
    idle(1);
    check("seq_pc5", 32'(bus.PROG_CTR), 32'h5);

    // Branch not taken, then taken.
    step(1, 0, 0, 0, 0, 0, 0);
    idle(4);
    step(0, 0, 1, 0, 0, 0, 3);
    check("br_not_taken", 32'(bus.PROG_CTR), 32'h5);
    step(0, 0, 1, 0, 0, 1, 3);
    check("br_taken", 32'(bus.PROG_CTR), 32'h080);

    // Jump beats branch; stall blocks jump; wrap at the top of PC space.
    step(0, 0, 1, 1, 0, 0, 1);
    check("jump_wins", 32'(bus.PROG_CTR), 32'h010);
    step(0, 1, 0, 1, 0, 0, 2);
    check("stall_hold", 32'(bus.PROG_CTR), 32'h010);
    step(0, 0, 0, 1, 0, 0, 2);
    check("jump_max", 32'(bus.PROG_CTR), 32'h3FF);
    idle(1);
    check("pc_wrap", 32'(bus.PROG_CTR), 32'h000);

    // Same-cycle read of a written entry sees the old target.
    step(0, 0, 0, 1, 0, 0, 1, 1, 1, 'h111);
    check("lut_old_val", 32'(bus.PROG_CTR), 32'h010);
    step(0, 0, 0, 1, 0, 0, 1);
    check("lut_new_val", 32'(bus.PROG_CTR), 32'h111);

    // Halt at 7, hold, restart.
    step(1, 0, 0, 0, 0, 0, 0);
    idle(7);
    step(0, 0, 0, 0, 1, 0, 0);
    check("halt_pc", 32'(bus.PROG_CTR), 32'h7);
    check("halt_done", 32'(bus.DONE), 32'h1);
    check("halt_valid", 32'(bus.FETCH_VALID), 32'h0);
    step(0, 0, 0, 1, 0, 0, 2);
    check("halt_hold", 32'(bus.PROG_CTR), 32'h7);
    step(1, 0, 0, 0, 0, 0, 0);
    check("restart_pc", 32'(bus.PROG_CTR), 32'h0);
    check("restart_done", 32'(bus.DONE), 32'h0);

    // Asynchronous reset mid-run.
    step(0, 0, 0, 1, 0, 0, 4);
    check("pre_rst_pc", 32'(bus.PROG_CTR), 32'h020);
    RESET_N = 1'b0;
    #2;
    model_reset();
    check("async_rst_pc", 32'(bus.PROG_CTR), 32'h0);
    check("async_rst_valid", 32'(bus.FETCH_VALID), 32'h0);
    check("async_rst_state", 32'(bus.state), 32'(IDLE));
    #1;
    RESET_N = 1'b1;
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0, 4);
    check("lut_cleared", 32'(bus.PROG_CTR), 32'h0);

`ifdef FETCH_TAKEN_COUNT_EN
    step(1, 0, 0, 0, 0, 0, 0, 1, 3, 'h040);
    step(0, 0, 1, 0, 0, 1, 3);
    step(0, 0, 1, 0, 0, 1, 3);
    step(0, 0, 1, 0, 0, 1, 3);
    step(0, 0, 1, 0, 0, 0, 3);
    step(0, 1, 0, 1, 0, 0, 3);
    check("cnt_three", 32'(bus.TAKEN_CNT), 32'd3);
    step(1, 0, 0, 0, 0, 0, 0);
    check("cnt_start_clr", 32'(bus.TAKEN_CNT), 32'd0);
`endif

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      step($urandom_range(0, 39) == 0, $urandom_range(0, 4) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0,
           $urandom_range(0, 24) == 0, 1'($urandom_range(0, 1)),
           int'($urandom_range(0, DEPTH - 1)),
           $urandom_range(0, 3) == 0, int'($urandom_range(0, DEPTH - 1)),
           int'($urandom_range(0, PC_MOD - 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Program-counter / instruction-fetch stage that sits directly downstream of the ALU and consumes its FLAG output to resolve conditional branches.
- Holds the PC.
- Selects the next PC from sequential increment, a branch-target lookup table (LUT), or hold.
- Sequences the processor through idle/run/halt via a START/DONE handshake with the testbench or top level.
- PROG_CTR drives instruction-memory address; decode logic feeds the control inputs back.

Parameters:
PC_W, 10, program counter width in bits; PC wraps modulo 2^PC_W
LUT_DEPTH, 16, number of branch-target LUT entries; LUT_IDX width = $clog2(LUT_DEPTH)
START_ADDR, 0, PC value loaded on reset and on every START

Ports:
CLK  in  1  system clock, rising-edge
RESET_N  in  1  asynchronous, active-low reset
START  in  1  level; begin/restart execution at START_ADDR
STALL  in  1  hold PC and ignore branch/jump/halt inputs this cycle
BRANCH_EN  in  1  current instruction is a conditional branch (taken when FLAG=1)
JUMP_EN  in  1  current instruction is an unconditional jump
HALT_REQ  in  1  current instruction is halt
LUT_IDX  in  $clog2(LUT_DEPTH)  branch-target LUT read index
FLAG  in  1  ALU flag, combinational from ALU
LUT_WE  in  1  LUT write enable
LUT_WADDR  in  $clog2(LUT_DEPTH)  LUT write index
LUT_WDATA  in  PC_W  LUT write data (absolute target address)
PROG_CTR  out  PC_W  current PC (registered)
FETCH_VALID  out  1  PROG_CTR addresses a live instruction
DONE  out  1  program halted; high until next START

Behaviour:
- Reset is asynchronous; clock is CLK.
- On reset:
  - state=IDLE, PROG_CTR=START_ADDR, FETCH_VALID=0, DONE=0.
  - All LUT entries = 0.
- States: IDLE, RUN, HALT. FETCH_VALID is 1 only in RUN. DONE is 1 only in HALT. Both are registered.
- IDLE:
  - START=1 -> RUN, PROG_CTR=START_ADDR.
  - Otherwise hold.
- RUN, priority high->low, evaluated each rising edge:
  1. START=1 -> PROG_CTR=START_ADDR, stay in RUN (restart).
  2. STALL=1 -> hold PROG_CTR and state.
  3. HALT_REQ=1 -> HALT; PROG_CTR holds (points at the halt instruction).
  4. JUMP_EN=1 -> PROG_CTR=LUT[LUT_IDX].
  5. BRANCH_EN=1 and FLAG=1 -> PROG_CTR=LUT[LUT_IDX].
  6. Else -> PROG_CTR=PROG_CTR+1, modulo 2^PC_W (max wraps to 0, no error).
- BRANCH_EN=1 with FLAG=0 -> sequential increment (not taken).
- JUMP_EN and BRANCH_EN both high -> jump wins, FLAG ignored.
- HALT:
  - START=1 -> RUN, PROG_CTR=START_ADDR, DONE cleared the same edge.
  - Otherwise all state holds.
- Latency: next-PC decision made from inputs in cycle N; new PROG_CTR is visible after edge N, i.e. one cycle. No delay slot.
- LUT:
  - Single write port, single combinational read port.
  - Write on a rising edge when LUT_WE=1; writes are accepted in any state.
  - Same-cycle read of the index being written returns the old value; the new value is visible the next cycle.
- Reset asserted mid-RUN: immediate return to reset values, including LUT clear.
- LUT_IDX >= LUT_DEPTH (non-power-of-two depth): target = START_ADDR.

Optional Feature:
Macro FETCH_TAKEN_COUNT_EN.
- Defined: adds output TAKEN_CNT (16 bits).
  - Counts edges where a jump or taken branch updates the PC in RUN.
  - Saturates at 16'hFFFF.
  - Cleared by reset and on START.
  - Not incremented on STALL cycles.
- Undefined: the port and counter logic are absent; all other behaviour is identical.

Decomposition:
- Package definitions adds:
  - enum fetch_state_e {IDLE, RUN, HALT}, declared with an explicit 2-bit encoding.
  - Default PC width constant.
  - Default LUT depth constant.
- One sub-module, branch_lut: register array with one synchronous write port, one combinational read port, and async active-low clear. Parameters LUT_DEPTH and PC_W.

Test Plan:
- Reset -> PROG_CTR=0, FETCH_VALID=0, DONE=0. Then START for 1 cycle, idle inputs 5 cycles -> PROG_CTR 0,1,2,3,4,5 and FETCH_VALID=1.
- LUT[3]=10'h080 written; at PC=4 drive BRANCH_EN=1, LUT_IDX=3, FLAG=0 -> PC=5. Repeat at PC=5 with FLAG=1 -> PC=0x080.
- JUMP_EN=1 and BRANCH_EN=1 with FLAG=0, LUT[1]=10'h010 -> PC=0x010. STALL=1 with JUMP_EN=1 -> PC unchanged.
- PC=10'h3FF, no control inputs -> PC=0x000.
- HALT_REQ at PC=7 -> DONE=1, FETCH_VALID=0, PC stays 7. START -> RUN, PC=0, DONE=0. RESET_N pulse mid-RUN at PC=0x020 -> PC=0 immediately, state IDLE.
- With FETCH_TAKEN_COUNT_EN defined: 3 taken branches, 1 not-taken, 1 stalled jump -> TAKEN_CNT=3. START -> TAKEN_CNT=0.
